// File: rtl/mul_add_seq.sv
// Sequential shift-and-add multiply-accumulate: product = multiplicand * multiplier + addend.
// Optional early termination when no multiplier bits remain: define MUL_ADD_EARLY_EXIT_EN.
module mul_add_seq #(
  parameter int unsigned SIZE = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE-1:0]   multiplicand,
  input  logic [SIZE-1:0]   multiplier,
  input  logic [SIZE-1:0]   addend,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [2*SIZE-1:0] product
);

  localparam int unsigned PW    = 2 * SIZE;
  localparam int unsigned CNT_W = $clog2(SIZE);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK_ZERO = 3'd1,
    ADD_SHIFT  = 3'd2,
    FINISH     = 3'd3
  } state_t;

  state_t           state, state_next;
  logic [PW-1:0]    mcand, mcand_next;
  logic [SIZE-1:0]  mplier, mplier_next;
  logic [PW-1:0]    acc, acc_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             last_step;

  assign product = acc;

  // Final shift-add step: fixed count, or optionally once no multiplier bits remain.
  always_comb begin
    last_step = (cnt == CNT_W'(SIZE - 1));
`ifdef MUL_ADD_EARLY_EXIT_EN
    if (mplier[SIZE-1:1] == '0) begin
      last_step = 1'b1;
    end
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_next  = state;
    mcand_next  = mcand;
    mplier_next = mplier;
    acc_next    = acc;
    cnt_next    = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          mcand_next  = {{SIZE{1'b0}}, multiplicand};
          mplier_next = multiplier;
          acc_next    = {{SIZE{1'b0}}, addend};
          cnt_next    = '0;
          state_next  = CHECK_ZERO;
        end
      end
      CHECK_ZERO: begin
        if ((mcand == '0) || (mplier == '0)) begin
          state_next = FINISH;
        end else begin
          state_next = ADD_SHIFT;
        end
      end
      ADD_SHIFT: begin
        if (mplier[0]) begin
          acc_next = acc + mcand;
        end
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        cnt_next    = cnt + CNT_W'(1);
        if (last_step) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      mcand    <= mcand_next;
      mplier   <= mplier_next;
      acc      <= acc_next;
      cnt      <= cnt_next;
      busy     <= (state_next != IDLE);
      done     <= (state_next == FINISH);
      overflow <= |acc_next[PW-1:SIZE];
    end
  end

endmodule
